tm1638_responder: RTL and testbench
===================================

TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 SHALL have parameter KEY_BYTES, default 4, meaning the number of key-scan bytes returned per read frame.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port tm_cs, input, 1, frame strobe (STB), active low, asynchronous to clk.
REQ-005 SHALL have port tm_clk, input, 1, serial bit clock from the host driver, asynchronous to clk.
REQ-006 SHALL have port tm_dio_in, input, 1, serial data from the host.
REQ-007 SHALL have port tm_dio_out, output, 1, serial key data to the host.
REQ-008 SHALL have port tm_dio_oe, output, 1, high when tm_dio_out is to be driven onto the shared DIO pin.
REQ-009 SHALL have port keys, input, 8*KEY_BYTES, key matrix state; byte 0 is bits [7:0].
REQ-010 SHALL have port ram_addr, input, 4, display RAM read address.
REQ-011 SHALL have port ram_data, output, 8, display RAM contents at ram_addr, combinational read.
REQ-012 SHALL have port disp_on, output, 1, display enable from the last display-control command.
REQ-013 SHALL have port brightness, output, 3, pulse-width setting from the last display-control command.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse on each frame end.
REQ-015 SHALL have port cmd_error, output, 1, one-cycle pulse when a command byte has bits[7:6]=00.

Function
REQ-016 SHALL pass tm_cs, tm_clk and tm_dio_in through 2-flop synchronizers and detect tm_clk rising and falling edges and tm_cs edges on the synchronized signals; correct operation requires clk >= 8x tm_clk.
REQ-017 SHALL implement states IDLE, CMD, WDATA, RDATA and SKIP; synchronized tm_cs falling moves any state to CMD with the bit counter cleared.
REQ-018 SHALL shift tm_dio_in LSB-first on each synchronized tm_clk rising edge in CMD and WDATA; the 8th edge completes a byte.
REQ-019 SHALL decode a completed CMD byte: 01xxxxxx data command latches auto_inc=~bit2; bits[1:0]=10 snapshots keys and enters RDATA; otherwise it enters SKIP.
REQ-020 SHALL decode 11xxaaaa as an address command: addr<=aaaa, enter WDATA.
REQ-021 SHALL decode 10xxdbbb as display control: disp_on<=d, brightness<=bbb, enter SKIP.
REQ-022 SHALL on 00xxxxxx pulse cmd_error for one cycle and enter SKIP.
REQ-023 SHALL on each completed WDATA byte write ram[addr]; if auto_inc, addr<=addr+1 with wrap 15->0; else addr is held.
REQ-024 SHALL make a written byte visible on ram_data no later than 4 clk cycles after the 8th tm_clk rising edge at the pins.
REQ-025 SHALL in RDATA, on each synchronized tm_clk falling edge, drive tm_dio_out<=snapshot[ptr] and tm_dio_oe<=1; the first falling edge after the command byte presents bit 0.
REQ-026 SHALL in RDATA increment ptr on each synchronized tm_clk rising edge; when ptr reaches 8*KEY_BYTES, it clears tm_dio_oe and enters SKIP.
REQ-027 SHALL ignore all tm_clk edges in IDLE and SKIP.
REQ-028 SHALL on synchronized tm_cs rising, from any non-IDLE state, enter IDLE, clear tm_dio_oe, discard any partial byte and pulse frame_done; addr, auto_inc, disp_on and brightness are retained.
REQ-029 SHALL give tm_cs rising priority over a tm_clk edge detected in the same cycle.
REQ-030 SHALL keep the key snapshot stable for the whole read frame regardless of keys changes.

Reset
REQ-031 SHALL on reset clear state to IDLE, all RAM bytes, addr, ptr, the bit counter, disp_on, brightness, tm_dio_out, tm_dio_oe, frame_done and cmd_error, and set auto_inc=1.
REQ-032 SHALL preset the synchronizer flops to idle levels on reset: tm_cs=1, tm_clk=1, dio=1.
REQ-033 SHALL treat reset asserted mid-frame as a full abort, with no RAM write and no frame_done.

Structure
REQ-034 SHALL take the command field codes (DATA=01, DISP=10, ADDR=11) and the read-mode code 10 from the shared apple_pkg package.
REQ-035 SHALL instantiate one sub-module, sync_edge (2-flop synchronizer plus rise/fall detect), three times.

Verification
REQ-036 SHALL cover: frame 0x40, then frame 0xC0,0x01,0x02,0x03 -> ram[0..2]=01,02,03, addr=3, two frame_done pulses.
REQ-037 SHALL cover: 0x44, then 0xCF,0xAA,0xBB (fixed address) -> ram[15]=BB and ram[0] unchanged; repeated with 0x40 -> ram[15]=AA, ram[0]=BB (wrap).
REQ-038 SHALL cover: keys=0x80402010, frame 0x42 then 32 clocks -> host samples bytes 10,20,40,80 LSB-first, and oe drops after bit 31.
REQ-039 SHALL cover: frame 0x8C -> disp_on=1, brightness=4; frame 0x05 -> one cmd_error pulse and all state unchanged.
REQ-040 SHALL cover: tm_cs raised after 5 bits of a WDATA byte -> no RAM write, frame_done pulses, and the next frame decodes correctly.
REQ-041 SHALL cover: reset asserted during RDATA -> tm_dio_oe=0 immediately and RAM all zero.

Source files
------------

// File: rtl/apple_pkg.sv
// Shared TM1638 protocol constants: FSM states and command-field codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apple_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        SKIP
    } state_t;

    // Command byte bits[7:6]; 00 is not a legal command.
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Data command bits[1:0] selecting a key-scan read.
    localparam logic [1:0] MODE_READ = 2'b10;

endpackage

// File: rtl/sync_edge.sv
// 2-flop synchronizer with rise/fall detection on the synchronized level.
// Latency: q follows d after 2 clk; rise/fall are combinational from the sync chain.
// Backpressure: none; edges are single-cycle pulses that must be consumed immediately.
// Ports: clk, reset (async high), d (async input), q (synced level), rise, fall.
module sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // All three flops preset to the idle level so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 slave emulation: decodes host commands into display RAM/control and returns key bytes.
// Latency: a written byte reaches ram_data 3 clk after the 8th tm_clk rise; read bits appear 3 clk after tm_clk fall.
// Backpressure: none; the host owns the serial clock, so clk must run at least 8x tm_clk.
// Ports: clk/reset; tm_cs/tm_clk/tm_dio_in from host, tm_dio_out/tm_dio_oe to the shared DIO pin;
//        keys (byte 0 = bits[7:0]); ram_addr -> ram_data combinational read; disp_on, brightness;
//        frame_done and cmd_error one-cycle pulses.
module tm1638_responder
    import apple_pkg::*;
#(
    parameter int KEY_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tm_cs,
    input  logic                   tm_clk,
    input  logic                   tm_dio_in,
    output logic                   tm_dio_out,
    output logic                   tm_dio_oe,
    input  logic [8*KEY_BYTES-1:0] keys,
    input  logic [3:0]             ram_addr,
    output logic [7:0]             ram_data,
    output logic                   disp_on,
    output logic [2:0]             brightness,
    output logic                   frame_done,
    output logic                   cmd_error
);

    localparam int                NBITS    = 8 * KEY_BYTES;
    localparam int                PTR_W    = $clog2(NBITS);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NBITS - 1);

    logic cs_q, cs_rise, cs_fall;
    logic clk_q, clk_rise, clk_fall;
    logic dio_q, dio_rise, dio_fall;

    sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk (clk), .reset(reset), .d(tm_cs),
        .q   (cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.RST_VAL(1'b1)) u_sync_clk (
        .clk (clk), .reset(reset), .d(tm_clk),
        .q   (clk_q), .rise(clk_rise), .fall(clk_fall)
    );

    sync_edge #(.RST_VAL(1'b1)) u_sync_dio (
        .clk (clk), .reset(reset), .d(tm_dio_in),
        .q   (dio_q), .rise(dio_rise), .fall(dio_fall)
    );

    // Only levels/edges the protocol needs are consumed; the rest are tied off here.
    logic sync_unused;
    assign sync_unused = ^{cs_q, clk_q, dio_rise, dio_fall};

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [3:0]        addr;
    logic              auto_inc;
    logic [PTR_W-1:0]  ptr;
    logic [NBITS-1:0]  snapshot;
    logic [7:0]        ram [16];

    // LSB-first: the newest bit enters at the top, so after 8 shifts bit 0 is the first one sent.
    logic [7:0] nxt_byte;
    assign nxt_byte = {dio_q, shreg[7:1]};

    assign ram_data = ram[ram_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            addr       <= 4'd0;
            auto_inc   <= 1'b1;
            ptr        <= '0;
            snapshot   <= '0;
            disp_on    <= 1'b0;
            brightness <= 3'd0;
            tm_dio_out <= 1'b0;
            tm_dio_oe  <= 1'b0;
            frame_done <= 1'b0;
            cmd_error  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                ram[i] <= 8'h00;
            end
        end else begin
            frame_done <= 1'b0;
            cmd_error  <= 1'b0;

            // Strobe edges outrank any tm_clk edge seen in the same cycle.
            if (cs_rise) begin
                bit_cnt <= 3'd0;
                if (state != IDLE) begin
                    state      <= IDLE;
                    tm_dio_oe  <= 1'b0;
                    frame_done <= 1'b1;
                end
            end else if (cs_fall) begin
                state     <= CMD;
                bit_cnt   <= 3'd0;
                tm_dio_oe <= 1'b0;
            end else begin
                case (state)
                    CMD: begin
                        if (clk_rise) begin
                            shreg   <= nxt_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (nxt_byte[7:6])
                                    CMD_DATA: begin
                                        auto_inc <= ~nxt_byte[2];
                                        if (nxt_byte[1:0] == MODE_READ) begin
                                            snapshot <= keys;
                                            ptr      <= '0;
                                            state    <= RDATA;
                                        end else begin
                                            state <= SKIP;
                                        end
                                    end
                                    CMD_DISP: begin
                                        disp_on    <= nxt_byte[3];
                                        brightness <= nxt_byte[2:0];
                                        state      <= SKIP;
                                    end
                                    CMD_ADDR: begin
                                        addr  <= nxt_byte[3:0];
                                        state <= WDATA;
                                    end
                                    default: begin
                                        cmd_error <= 1'b1;
                                        state     <= SKIP;
                                    end
                                endcase
                            end
                        end
                    end

                    WDATA: begin
                        if (clk_rise) begin
                            shreg   <= nxt_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ram[addr] <= nxt_byte;
                                if (auto_inc) begin
                                    addr <= addr + 4'd1;   // 4-bit wrap 15 -> 0
                                end
                            end
                        end
                    end

                    RDATA: begin
                        // Data changes on the falling edge so it is stable for the host's rising-edge sample.
                        if (clk_fall) begin
                            tm_dio_out <= snapshot[ptr];
                            tm_dio_oe  <= 1'b1;
                        end else if (clk_rise) begin
                            if (ptr == PTR_LAST) begin
                                ptr       <= '0;
                                tm_dio_oe <= 1'b0;
                                state     <= SKIP;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end
                    end

                    default: ;  // IDLE and SKIP ignore tm_clk
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: bit-bangs host frames and checks RAM, control and key readback.
// Latency: host half-bit is 8 clk, comfortably above the 3-clk sync/response path.
// Backpressure: n/a.
module tb_tm1638_responder;

    localparam int H = 80;   // host half bit period in ns (8 clk)

    logic        clk = 1'b0;
    logic        reset;
    logic        tm_cs;
    logic        tm_clk;
    logic        tm_dio_in;
    logic        tm_dio_out;
    logic        tm_dio_oe;
    logic [31:0] keys;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        disp_on;
    logic [2:0]  brightness;
    logic        frame_done;
    logic        cmd_error;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    tm1638_responder #(.KEY_BYTES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tm_cs      (tm_cs),
        .tm_clk     (tm_clk),
        .tm_dio_in  (tm_dio_in),
        .tm_dio_out (tm_dio_out),
        .tm_dio_oe  (tm_dio_oe),
        .keys       (keys),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .disp_on    (disp_on),
        .brightness (brightness),
        .frame_done (frame_done),
        .cmd_error  (cmd_error)
    );

    // Pulse counters sampled on the inactive edge; a stretched pulse would count twice.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (cmd_error)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            tm_clk    = 1'b0;
            tm_dio_in = b[i];
            #H;
            tm_clk    = 1'b1;
            #H;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            tm_clk    = 1'b0;
            tm_dio_in = b[i];
            #H;
            tm_clk    = 1'b1;
            #H;
        end
    endtask

    task automatic frame_start();
        tm_cs = 1'b0;
        #H;
    endtask

    task automatic frame_end();
        tm_cs = 1'b1;
        tm_dio_in = 1'b1;
        #(2*H);
    endtask

    task automatic frame1(input logic [7:0] b);
        frame_start();
        send_byte(b);
        frame_end();
    endtask

    task automatic ram_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        ram_addr = a;
        #1;
        check(tag, {24'h0, ram_data}, {24'h0, exp});
    endtask

    logic [31:0] rx;
    logic        oe_all;
    int          fd_base;

    initial begin
        reset     = 1'b1;
        tm_cs     = 1'b1;
        tm_clk    = 1'b1;
        tm_dio_in = 1'b1;
        keys      = 32'h0;
        ram_addr  = 4'd0;
        #33;
        check("rst_oe",     {31'h0, tm_dio_oe},  32'h0);
        check("rst_disp",   {31'h0, disp_on},    32'h0);
        check("rst_bright", {29'h0, brightness}, 32'h0);
        ram_chk("rst_ram0", 4'd0, 8'h00);
        reset = 1'b0;
        #40;

        // Auto-increment write burst.
        fd_base = fd_cnt;
        frame1(8'h40);
        frame_start();
        send_byte(8'hC0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        frame_end();
        ram_chk("wr_ram0", 4'd0, 8'h01);
        ram_chk("wr_ram1", 4'd1, 8'h02);
        ram_chk("wr_ram2", 4'd2, 8'h03);
        check("wr_addr", {28'h0, dut.addr}, 32'd3);
        check("wr_fd", fd_cnt - fd_base, 32'd2);

        // Fixed address, then auto-increment wrap 15 -> 0.
        frame1(8'h44);
        frame_start();
        send_byte(8'hCF);
        send_byte(8'hAA);
        send_byte(8'hBB);
        frame_end();
        ram_chk("fix_ram15", 4'd15, 8'hBB);
        ram_chk("fix_ram0",  4'd0,  8'h01);
        frame1(8'h40);
        frame_start();
        send_byte(8'hCF);
        send_byte(8'hAA);
        send_byte(8'hBB);
        frame_end();
        ram_chk("wrap_ram15", 4'd15, 8'hAA);
        ram_chk("wrap_ram0",  4'd0,  8'hBB);

        // Display control and illegal command.
        frame1(8'h8C);
        check("disp_on", {31'h0, disp_on},    32'h1);
        check("bright4", {29'h0, brightness}, 32'h4);
        err_cnt = 0;
        frame1(8'h05);
        check("cmderr_cnt", err_cnt, 32'd1);
        check("err_disp",   {31'h0, disp_on},    32'h1);
        check("err_bright", {29'h0, brightness}, 32'h4);
        ram_chk("err_ram15", 4'd15, 8'hAA);

        // Aborted write byte.
        fd_base = fd_cnt;
        frame_start();
        send_byte(8'hC5);
        send_bits(8'h77, 5);
        frame_end();
        ram_chk("abort_ram5", 4'd5, 8'h00);
        check("abort_fd", fd_cnt - fd_base, 32'd1);
        frame_start();
        send_byte(8'hC5);
        send_byte(8'h99);
        frame_end();
        ram_chk("after_abort_ram5", 4'd5, 8'h99);

        // Key readback; keys change mid-frame must not disturb the snapshot.
        keys   = 32'h80402010;
        oe_all = 1'b1;
        rx     = 32'h0;
        frame_start();
        send_byte(8'h42);
        for (int i = 0; i < 32; i++) begin
            tm_clk = 1'b0;
            #H;
            rx[i]  = tm_dio_out;
            oe_all = oe_all & tm_dio_oe;
            if (i == 8) keys = 32'hFFFF_FFFF;
            tm_clk = 1'b1;
            #H;
        end
        check("rd_byte0", {24'h0, rx[7:0]},   32'h10);
        check("rd_byte1", {24'h0, rx[15:8]},  32'h20);
        check("rd_byte2", {24'h0, rx[23:16]}, 32'h40);
        check("rd_byte3", {24'h0, rx[31:24]}, 32'h80);
        check("rd_oe_on", {31'h0, oe_all},    32'h1);
        check("rd_oe_off", {31'h0, tm_dio_oe}, 32'h0);
        frame_end();

        // Reset in the middle of a read frame.
        keys = 32'h0000_00FF;
        fd_base = fd_cnt;
        frame_start();
        send_byte(8'h42);
        send_bits(8'hFF, 4);
        tm_clk = 1'b0;
        #H;
        check("rst_mid_oe_before", {31'h0, tm_dio_oe}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_mid_oe", {31'h0, tm_dio_oe}, 32'h0);
        tm_cs  = 1'b1;
        tm_clk = 1'b1;
        tm_dio_in = 1'b1;
        #40;
        for (int a = 0; a < 16; a++) begin
            ram_chk("rst_mid_ram", 4'(a), 8'h00);
        end
        check("rst_mid_disp", {31'h0, disp_on}, 32'h0);
        reset = 1'b0;
        #80;
        check("rst_mid_fd", fd_cnt - fd_base, 32'd0);
        frame1(8'h8F);
        check("post_rst_disp",   {31'h0, disp_on},    32'h1);
        check("post_rst_bright", {29'h0, brightness}, 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
